tdc_rx: RTL and testbench

//  Core-side receiver for the TDC result burst interface (TDC_Odata/Oint/Onum/Olast/Ovalid/Oready/INT).

---
 rtl/tdc_pkg.sv | 29 ++
 rtl/tdc_rx_fifo.sv | 58 +++++
 rtl/tdc_rx.sv | 185 ++++++++++++++++++
 tb/tb_tdc_rx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result-burst receiver.
//   DefTofW / DefIntW : default depth and intensity widths (match TDC_Odata / TDC_Oint)
//   rx_state_e        : receiver FSM states
//   rx_rec_t          : one reduced burst record {tof, intens, cnt, err}
//   sat_inc2          : 2-bit increment that saturates at 3
package tdc_pkg;

  localparam int unsigned DefTofW = 10;
  localparam int unsigned DefIntW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRecv,
    StPush
  } rx_state_e;

  typedef struct packed {
    logic [DefTofW-1:0] tof;
    logic [DefIntW-1:0] intens;
    logic [1:0]         cnt;
    logic               err;
  } rx_rec_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/tdc_rx_fifo.sv
// Single-clock synchronous FIFO of receiver records.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers only)
//   push_i/data_i : write one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   data_o        : head entry, combinational
//   full_o/empty_o: occupancy flags
// Push and pop may occur in the same cycle.
module tdc_rx_fifo #(
  parameter int unsigned Width = 18,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/tdc_rx.sv
// Core-side receiver for the TDC result burst interface.
// Wakes on TDC_INT, raises TDC_Oready, collects 1-3 beats until TDC_Olast, reduces the burst
// to one record {tof, int, cnt, err} and queues it in a small FIFO toward the result port.
//   clk, rst_n          : logic clock, asynchronous active-low reset
//   TDC_INT             : burst-available pulse
//   TDC_Onum/Odata/Oint : beat count announcement, beat depth, beat intensity
//   TDC_Ovalid/Olast    : beat valid, final beat
//   TDC_Oready          : receiver ready (registered)
//   res_*               : FIFO head record, res_valid = FIFO not empty, pop on res_valid&res_ready
//   miss_cnt            : saturating count of TDC_INT pulses that could not be accepted
// Build option TDC_RX_MAXINT_EN: when defined the record keeps the beat with the highest
// intensity (earliest wins ties); otherwise it keeps the first beat.
module tdc_rx
  import tdc_pkg::*;
#(
  parameter int unsigned TOF_W      = DefTofW,
  parameter int unsigned INT_W      = DefIntW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             TDC_INT,
  input  logic [1:0]       TDC_Onum,
  input  logic [TOF_W-1:0] TDC_Odata,
  input  logic [INT_W-1:0] TDC_Oint,
  input  logic             TDC_Ovalid,
  input  logic             TDC_Olast,
  output logic             TDC_Oready,
  output logic [TOF_W-1:0] res_tof,
  output logic [INT_W-1:0] res_int,
  output logic [1:0]       res_cnt,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       miss_cnt
);

  localparam int unsigned RecW = TOF_W + INT_W + 3;
  localparam int unsigned TmoW = $clog2(TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  rx_state_e        state_q, state_d;
  logic             oready_q, oready_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]       onum_q, onum_d;
  logic             err_q, err_d;
  logic [TOF_W-1:0] sel_tof_q, sel_tof_d;
  logic [INT_W-1:0] sel_int_q, sel_int_d;
  logic [7:0]       miss_q, miss_d;

  logic             beat;
  logic             push, pop, full, empty;
  logic [RecW-1:0]  push_data, head;

  assign beat = TDC_Ovalid & oready_q;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    beat_cnt_d = beat_cnt_q;
    onum_d     = onum_q;
    err_d      = err_q;
    sel_tof_d  = sel_tof_q;
    sel_int_d  = sel_int_q;
    miss_d     = miss_q;
    push       = 1'b0;
    push_data  = {sel_tof_q, sel_int_q, beat_cnt_q, err_q};

    unique case (state_q)
      StIdle: begin
        if (TDC_INT && !full) begin
          state_d    = StArm;
          tmo_d      = '0;
          beat_cnt_d = '0;
          onum_d     = '0;
          err_d      = 1'b0;
          sel_tof_d  = '0;
          sel_int_d  = '0;
        end
      end
      StArm: begin
        if (beat) begin
          onum_d     = TDC_Onum;
          beat_cnt_d = 2'd1;
          sel_tof_d  = TDC_Odata;
          sel_int_d  = TDC_Oint;
          if (TDC_Olast) begin
            // Single-beat burst: count is 1, so Onum must be exactly 1.
            err_d   = (TDC_Onum != 2'd1);
            state_d = StPush;
          end else begin
            state_d = StRecv;
          end
        end else if (tmo_q == TmoLast) begin
          // Timeout writes the error record directly; FIFO has room since ARM implies not full.
          push      = 1'b1;
          push_data = {{(RecW-1){1'b0}}, 1'b1};
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRecv: begin
        if (beat) begin
          beat_cnt_d = sat_inc2(beat_cnt_q);
          if (beat_cnt_q == 2'd3) begin
            err_d = 1'b1;
          end
`ifdef TDC_RX_MAXINT_EN
          if (TDC_Oint > sel_int_q) begin
            sel_tof_d = TDC_Odata;
            sel_int_d = TDC_Oint;
          end
`endif
          if (TDC_Olast) begin
            if ((beat_cnt_d != onum_q) || (onum_q == 2'd0)) begin
              err_d = 1'b1;
            end
            state_d = StPush;
          end
        end
      end
      StPush: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (TDC_INT && ((state_q != StIdle) || full) && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end

    oready_d = (state_d == StArm) || (state_d == StRecv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      oready_q   <= 1'b0;
      tmo_q      <= '0;
      beat_cnt_q <= '0;
      onum_q     <= '0;
      err_q      <= 1'b0;
      sel_tof_q  <= '0;
      sel_int_q  <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      oready_q   <= oready_d;
      tmo_q      <= tmo_d;
      beat_cnt_q <= beat_cnt_d;
      onum_q     <= onum_d;
      err_q      <= err_d;
      sel_tof_q  <= sel_tof_d;
      sel_int_q  <= sel_int_d;
      miss_q     <= miss_d;
    end
  end

  tdc_rx_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop        = res_ready & ~empty;
  assign res_valid  = ~empty;
  assign TDC_Oready = oready_q;
  assign miss_cnt   = miss_q;

  // Head fields are forced to zero while empty so stale entries never show.
  assign {res_tof, res_int, res_cnt, res_err} = empty ? '0 : head;

endmodule

// File: tb/tb_tdc_rx.sv
module tb_tdc_rx;
  import tdc_pkg::*;

  localparam int TOF_W      = 10;
  localparam int INT_W      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;
`ifdef TDC_RX_MAXINT_EN
  localparam bit MaxInt = 1'b1;
`else
  localparam bit MaxInt = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             TDC_INT;
  logic [1:0]       TDC_Onum;
  logic [TOF_W-1:0] TDC_Odata;
  logic [INT_W-1:0] TDC_Oint;
  logic             TDC_Ovalid;
  logic             TDC_Olast;
  logic             TDC_Oready;
  logic [TOF_W-1:0] res_tof;
  logic [INT_W-1:0] res_int;
  logic [1:0]       res_cnt;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       miss_cnt;

  tdc_rx #(
    .TOF_W      (TOF_W),
    .INT_W      (INT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .TDC_INT    (TDC_INT),
    .TDC_Onum   (TDC_Onum),
    .TDC_Odata  (TDC_Odata),
    .TDC_Oint   (TDC_Oint),
    .TDC_Ovalid (TDC_Ovalid),
    .TDC_Olast  (TDC_Olast),
    .TDC_Oready (TDC_Oready),
    .res_tof    (res_tof),
    .res_int    (res_int),
    .res_cnt    (res_cnt),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .miss_cnt   (miss_cnt)
  );

  always #2 clk = ~clk;

  typedef struct packed {
    logic [1:0]            onum;
    logic [2:0]            n;
    logic [3:0][TOF_W-1:0] tofs;
    logic [3:0][INT_W-1:0] ints;
    logic [TOF_W-1:0]      tof_mx;
    logic [INT_W-1:0]      int_mx;
    logic [TOF_W-1:0]      tof_f;
    logic [INT_W-1:0]      int_f;
    logic [1:0]            cnt;
    logic                  err;
  } vec_t;

  vec_t    vecs [7];
  rx_rec_t exp_q [$];
  int      checks = 0;
  int      errors = 0;
  int      exp_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: reduce a burst from the rules alone.
  function automatic rx_rec_t model(input logic [1:0] onum, input int n,
                                    input logic [3:0][TOF_W-1:0] tofs,
                                    input logic [3:0][INT_W-1:0] ints);
    rx_rec_t r;
    int best = 0;
    if (MaxInt) begin
      for (int i = 1; i < n; i++) if (ints[i] > ints[best]) best = i;
    end
    r.tof    = tofs[best];
    r.intens = ints[best];
    r.cnt    = (n > 3) ? 2'd3 : 2'(n);
    r.err    = (onum == 2'd0) || (n != int'(onum));
    return r;
  endfunction

  // Entered and left on a negedge; returns in the cycle after the Olast beat was taken.
  task automatic send_burst(input logic [1:0] onum, input int n,
                            input logic [3:0][TOF_W-1:0] tofs,
                            input logic [3:0][INT_W-1:0] ints, input bit bubbles);
    int w = 0;
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    check("oready_rise", TDC_Oready, 1);
    while (!TDC_Oready && w < 8) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        TDC_Ovalid = 1'b0;
        TDC_Odata  = TOF_W'($urandom);
        TDC_Oint   = INT_W'($urandom);
        TDC_Olast  = 1'($urandom);
        @(negedge clk);
      end
      TDC_Ovalid = 1'b1;
      TDC_Onum   = onum;
      TDC_Odata  = tofs[i];
      TDC_Oint   = ints[i];
      TDC_Olast  = (i == n - 1);
      @(negedge clk);
    end
    TDC_Ovalid = 1'b0;
    TDC_Olast  = 1'b0;
  endtask

  task automatic pop_expect(input string name, input rx_rec_t e);
    int w = 0;
    while (!res_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_valid"}, res_valid, 1);
    check({name, "_tof"}, res_tof, e.tof);
    check({name, "_int"}, res_int, e.intens);
    check({name, "_cnt"}, res_cnt, e.cnt);
    check({name, "_err"}, res_err, e.err);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic rand_burst(output logic [1:0] onum, output int n,
                            output logic [3:0][TOF_W-1:0] tofs,
                            output logic [3:0][INT_W-1:0] ints);
    onum = 2'($urandom_range(0, 3));
    n    = $urandom_range(1, 4);
    for (int i = 0; i < 4; i++) begin
      tofs[i] = TOF_W'($urandom);
      ints[i] = INT_W'($urandom_range(0, 7));  // narrow range forces ties
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rx_rec_t               e;
    logic [1:0]            onum;
    int                    n;
    int                    hi;
    logic [3:0][TOF_W-1:0] tofs;
    logic [3:0][INT_W-1:0] ints;

    vecs[0] = '{onum: 2'd1, n: 3'd1, tofs: {10'h0, 10'h0, 10'h0, 10'h05A},
                ints: {5'd0, 5'd0, 5'd0, 5'd7}, tof_mx: 10'h05A, int_mx: 5'd7,
                tof_f: 10'h05A, int_f: 5'd7, cnt: 2'd1, err: 1'b0};
    vecs[1] = '{onum: 2'd3, n: 3'd3, tofs: {10'h0, 10'h030, 10'h020, 10'h010},
                ints: {5'd0, 5'd9, 5'd9, 5'd3}, tof_mx: 10'h020, int_mx: 5'd9,
                tof_f: 10'h010, int_f: 5'd3, cnt: 2'd3, err: 1'b0};
    vecs[2] = '{onum: 2'd3, n: 3'd2, tofs: {10'h0, 10'h0, 10'h222, 10'h111},
                ints: {5'd0, 5'd0, 5'd12, 5'd4}, tof_mx: 10'h222, int_mx: 5'd12,
                tof_f: 10'h111, int_f: 5'd4, cnt: 2'd2, err: 1'b1};
    vecs[3] = '{onum: 2'd0, n: 3'd1, tofs: {10'h0, 10'h0, 10'h0, 10'h3FF},
                ints: {5'd0, 5'd0, 5'd0, 5'd31}, tof_mx: 10'h3FF, int_mx: 5'd31,
                tof_f: 10'h3FF, int_f: 5'd31, cnt: 2'd1, err: 1'b1};
    vecs[4] = '{onum: 2'd2, n: 3'd2, tofs: {10'h0, 10'h0, 10'h002, 10'h001},
                ints: {5'd0, 5'd0, 5'd8, 5'd8}, tof_mx: 10'h001, int_mx: 5'd8,
                tof_f: 10'h001, int_f: 5'd8, cnt: 2'd2, err: 1'b0};
    vecs[5] = '{onum: 2'd1, n: 3'd2, tofs: {10'h0, 10'h0, 10'h006, 10'h005},
                ints: {5'd0, 5'd0, 5'd2, 5'd1}, tof_mx: 10'h006, int_mx: 5'd2,
                tof_f: 10'h005, int_f: 5'd1, cnt: 2'd2, err: 1'b1};
    vecs[6] = '{onum: 2'd3, n: 3'd4, tofs: {10'h004, 10'h003, 10'h002, 10'h001},
                ints: {5'd4, 5'd3, 5'd2, 5'd1}, tof_mx: 10'h004, int_mx: 5'd4,
                tof_f: 10'h001, int_f: 5'd1, cnt: 2'd3, err: 1'b1};

    rst_n = 1'b0; TDC_INT = 1'b0; TDC_Onum = '0; TDC_Odata = '0; TDC_Oint = '0;
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0; res_ready = 1'b0;
    #9;
    check("rst_oready", TDC_Oready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_head", {res_tof, res_int, res_cnt, res_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_oready", TDC_Oready, 0);

    // Directed vectors, each also checks the two-cycle Olast-to-valid latency.
    for (int v = 0; v < 7; v++) begin
      send_burst(vecs[v].onum, int'(vecs[v].n), vecs[v].tofs, vecs[v].ints, 1'b0);
      check($sformatf("v%0d_lat1", v), res_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_lat2", v), res_valid, 1);
      e.tof    = MaxInt ? vecs[v].tof_mx : vecs[v].tof_f;
      e.intens = MaxInt ? vecs[v].int_mx : vecs[v].int_f;
      e.cnt    = vecs[v].cnt;
      e.err    = vecs[v].err;
      pop_expect($sformatf("v%0d", v), e);
    end

    // Timeout: Oready held for exactly TIMEOUT cycles, then an error record.
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    hi = 0;
    while (TDC_Oready && hi < 200) begin
      @(negedge clk);
      hi++;
    end
    check("tmo_cycles", hi, TIMEOUT);
    e = '{tof: '0, intens: '0, cnt: 2'd0, err: 1'b1};
    pop_expect("tmo_rec", e);
    send_burst(vecs[0].onum, 1, vecs[0].tofs, vecs[0].ints, 1'b0);
    @(negedge clk);
    pop_expect("after_tmo", model(vecs[0].onum, 1, vecs[0].tofs, vecs[0].ints));

    // INT while mid-burst is dropped and counted.
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    TDC_Ovalid = 1'b1; TDC_Onum = 2'd2; TDC_Odata = 10'h0AA; TDC_Oint = 5'd3; TDC_Olast = 1'b0;
    @(negedge clk);
    TDC_Ovalid = 1'b0;
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    exp_miss++;
    check("busy_miss", miss_cnt, exp_miss);
    check("busy_oready", TDC_Oready, 1);
    TDC_Ovalid = 1'b1; TDC_Odata = 10'h0BB; TDC_Oint = 5'd6; TDC_Olast = 1'b1;
    @(negedge clk);
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    e.tof = MaxInt ? 10'h0BB : 10'h0AA; e.intens = MaxInt ? 5'd6 : 5'd3;
    e.cnt = 2'd2; e.err = 1'b0;
    pop_expect("busy_rec", e);

    // Fill the FIFO, then a fifth INT must not arm.
    for (int b = 0; b < FIFO_DEPTH; b++) begin
      rand_burst(onum, n, tofs, ints);
      send_burst(onum, n, tofs, ints, 1'b1);
      @(negedge clk);
      exp_q.push_back(model(onum, n, tofs, ints));
    end
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    exp_miss++;
    hi = 0;
    for (int c = 0; c < 4; c++) begin
      if (TDC_Oready) hi++;
      @(negedge clk);
    end
    check("full_no_arm", hi, 0);
    check("full_miss", miss_cnt, exp_miss);
    for (int b = 0; b < FIFO_DEPTH; b++) pop_expect($sformatf("drain%0d", b), exp_q.pop_front());
    check("drained", res_valid, 0);

    // Randomised bursts with bubbles and lazy draining.
    for (int it = 0; it < 40; it++) begin
      while (exp_q.size() >= FIFO_DEPTH || (exp_q.size() > 0 && $urandom_range(0, 2) == 0))
        pop_expect($sformatf("rnd%0d", it), exp_q.pop_front());
      rand_burst(onum, n, tofs, ints);
      send_burst(onum, n, tofs, ints, 1'b1);
      @(negedge clk);
      exp_q.push_back(model(onum, n, tofs, ints));
    end
    while (exp_q.size() > 0) pop_expect("rnd_tail", exp_q.pop_front());
    check("rnd_miss", miss_cnt, exp_miss);

    // Reset in the middle of a burst with a record queued and misses counted.
    send_burst(vecs[0].onum, 1, vecs[0].tofs, vecs[0].ints, 1'b0);
    @(negedge clk);
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    TDC_Ovalid = 1'b1; TDC_Onum = 2'd3; TDC_Odata = 10'h155; TDC_Oint = 5'd9; TDC_Olast = 1'b0;
    @(negedge clk);
    TDC_Ovalid = 1'b0;
    TDC_INT = 1'b1;
    @(negedge clk);
    TDC_INT = 1'b0;
    check("pre_rst_miss", miss_cnt, exp_miss + 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oready", TDC_Oready, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_miss", miss_cnt, 0);
    exp_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_burst(vecs[1].onum, 3, vecs[1].tofs, vecs[1].ints, 1'b0);
    @(negedge clk);
    pop_expect("post_rst", model(vecs[1].onum, 3, vecs[1].tofs, vecs[1].ints));
    check("post_rst_empty", res_valid, 0);
    check("post_rst_miss", miss_cnt, exp_miss);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
